// File: rtl/adder_response_checker.sv
// Response checker for adder/subtractor cores: recomputes the golden result in a 2-stage pipeline and counts failures.
// Optional first-failure capture (fail_index/fail_s_exp/fail_s_obs) is built when CHECKER_FIRST_FAIL_CAPTURE_EN is defined.
module adder_response_checker #(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_VECTORS   = 2**DATA_WIDTH,
  parameter int ERR_CNT_WIDTH = 16,
  localparam int CNT_WIDTH    = $clog2(NUM_VECTORS+1)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    A,
  input  logic [DATA_WIDTH-1:0]    B,
  input  logic                     Cin,
  input  logic                     SUB,
  input  logic [DATA_WIDTH-1:0]    S,
  input  logic                     CF,
  input  logic                     OF,
  output logic                     mismatch,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0]     chk_count,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [CNT_WIDTH-1:0]     fail_index,
  output logic [DATA_WIDTH-1:0]    fail_s_exp,
  output logic [DATA_WIDTH-1:0]    fail_s_obs,
  output logic [1:0]               state_dbg
);

  // Handshake: a vector transfers on a rising edge where in_valid && in_ready; in_valid may be held through any stall.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] NV      = CNT_WIDTH'(NUM_VECTORS);
  localparam logic [CNT_WIDTH-1:0] NV_LAST = CNT_WIDTH'(NUM_VECTORS-1);

  state_t                   state_q;
  logic [CNT_WIDTH-1:0]     acc_cnt_q, acc_cnt_d;
  logic [CNT_WIDTH-1:0]     chk_cnt_q, chk_cnt_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                     mismatch_q;

  logic                     s1_valid_q;
  logic [DATA_WIDTH-1:0]    s1_a_q, s1_b_q, s1_s_q;
  logic                     s1_cin_q, s1_sub_q, s1_cf_q, s1_of_q;

  logic                     accept, start_run, fail;
  logic [DATA_WIDTH-1:0]    b_eff;
  logic                     c0, of_exp;
  logic [DATA_WIDTH:0]      sum_exp;

  assign in_ready  = (state_q == ST_RUN) && (acc_cnt_q < NV);
  assign accept    = in_valid && in_ready;
  assign start_run = START && (state_q != ST_RUN);

  // Golden model from the stage-1 registers; subtract is A + ~B + 1, so Cin is ignored there.
  assign b_eff   = s1_sub_q ? ~s1_b_q : s1_b_q;
  assign c0      = s1_sub_q ? 1'b1 : s1_cin_q;
  assign sum_exp = {1'b0, s1_a_q} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, c0};
  assign of_exp  = (s1_a_q[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1]) &&
                   (sum_exp[DATA_WIDTH-1] != s1_a_q[DATA_WIDTH-1]);
  assign fail    = s1_valid_q &&
                   ((sum_exp != {s1_cf_q, s1_s_q}) || (of_exp != s1_of_q));

  always_comb begin
    acc_cnt_d = accept ? acc_cnt_q + 1'b1 : acc_cnt_q;
    chk_cnt_d = s1_valid_q ? chk_cnt_q + 1'b1 : chk_cnt_q;
    err_cnt_d = (fail && (err_cnt_q != '1)) ? err_cnt_q + 1'b1 : err_cnt_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      acc_cnt_q  <= '0;
      chk_cnt_q  <= '0;
      err_cnt_q  <= '0;
      mismatch_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_s_q     <= '0;
      s1_cin_q   <= 1'b0;
      s1_sub_q   <= 1'b0;
      s1_cf_q    <= 1'b0;
      s1_of_q    <= 1'b0;
    end else if (start_run) begin
      state_q    <= ST_RUN;
      acc_cnt_q  <= '0;
      chk_cnt_q  <= '0;
      err_cnt_q  <= '0;
      mismatch_q <= 1'b0;
      s1_valid_q <= 1'b0;
    end else begin
      acc_cnt_q  <= acc_cnt_d;
      chk_cnt_q  <= chk_cnt_d;
      err_cnt_q  <= err_cnt_d;
      mismatch_q <= fail;
      s1_valid_q <= accept;
      if (accept) begin
        s1_a_q   <= A;
        s1_b_q   <= B;
        s1_s_q   <= S;
        s1_cin_q <= Cin;
        s1_sub_q <= SUB;
        s1_cf_q  <= CF;
        s1_of_q  <= OF;
      end
      if (s1_valid_q && (chk_cnt_q == NV_LAST))
        state_q <= ST_DONE;
    end
  end

`ifdef CHECKER_FIRST_FAIL_CAPTURE_EN
  logic [CNT_WIDTH-1:0]  fail_index_q;
  logic [DATA_WIDTH-1:0] fail_s_exp_q, fail_s_obs_q;

  // Checks complete in accept order, so chk_cnt_q is the index of the vector being checked.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fail_index_q <= '0;
      fail_s_exp_q <= '0;
      fail_s_obs_q <= '0;
    end else if (start_run) begin
      fail_index_q <= '0;
      fail_s_exp_q <= '0;
      fail_s_obs_q <= '0;
    end else if (fail && (err_cnt_q == '0)) begin
      fail_index_q <= chk_cnt_q;
      fail_s_exp_q <= sum_exp[DATA_WIDTH-1:0];
      fail_s_obs_q <= s1_s_q;
    end
  end

  assign fail_index = fail_index_q;
  assign fail_s_exp = fail_s_exp_q;
  assign fail_s_obs = fail_s_obs_q;
`else
  assign fail_index = '0;
  assign fail_s_exp = '0;
  assign fail_s_obs = '0;
`endif

  assign mismatch  = mismatch_q;
  assign err_count = err_cnt_q;
  assign chk_count = chk_cnt_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign pass      = (state_q == ST_DONE) && (err_cnt_q == '0);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_adder_response_checker.sv
// Scoreboard bench for adder_response_checker: directed vectors feed an expected queue, a negedge monitor checks each completed check.
module tb_adder_response_checker;

  localparam int DW = 8;
  localparam int NV = 256;
  localparam int CW = 9;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START, in_valid, in_ready;
  logic [DW-1:0] A, B, S;
  logic          Cin, SUB, CF, OF;
  logic          mismatch, busy, done, pass;
  logic [15:0]   err_count;
  logic [CW-1:0] chk_count, fail_index;
  logic [DW-1:0] fail_s_exp, fail_s_obs;
  logic [1:0]    state_dbg;

  logic          start2, valid2, ready2, mismatch2, busy2, done2, pass2;
  logic [1:0]    err2, st2;
  logic [2:0]    chk2, fi2;
  logic [DW-1:0] fse2, fso2;

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            exp_err = 0;
  logic [32:0]   exp_q[$];
  logic [CW-1:0] prev_chk = '0;
  logic [DW-1:0] first_fail_exp, first_fail_obs;
  logic          first_fail_seen;

  adder_response_checker #(.DATA_WIDTH(DW), .NUM_VECTORS(NV), .ERR_CNT_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .START(START), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .SUB(SUB), .S(S), .CF(CF), .OF(OF),
    .mismatch(mismatch), .err_count(err_count), .chk_count(chk_count),
    .busy(busy), .done(done), .pass(pass), .fail_index(fail_index),
    .fail_s_exp(fail_s_exp), .fail_s_obs(fail_s_obs), .state_dbg(state_dbg)
  );

  adder_response_checker #(.DATA_WIDTH(DW), .NUM_VECTORS(6), .ERR_CNT_WIDTH(2)) dut_sat (
    .CLK(CLK), .RST(RST), .START(start2), .in_valid(valid2), .in_ready(ready2),
    .A(A), .B(B), .Cin(Cin), .SUB(SUB), .S(S), .CF(CF), .OF(OF),
    .mismatch(mismatch2), .err_count(err2), .chk_count(chk2),
    .busy(busy2), .done(done2), .pass(pass2), .fail_index(fi2),
    .fail_s_exp(fse2), .fail_s_obs(fso2), .state_dbg(st2)
  );

  // Clock / cycle counter
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference adder written in integer arithmetic: returns {CF, OF, S}.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic cin, input logic sub);
    int ua, ub, sa, sb, u, sr;
    logic cf, of;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    if (!sub) begin
      u  = ua + ub + int'(cin);
      cf = (u > 255);
      sr = sa + sb + int'(cin);
    end else begin
      u  = ua - ub + 256;
      cf = (ua >= ub);
      sr = sa - sb;
    end
    of = (sr > 127) || (sr < -128);
    return {cf, of, u[7:0]};
  endfunction

  task automatic get_vec(input int i, input int run, output logic [7:0] a, output logic [7:0] b,
                         output logic cin, output logic sub);
    a   = 8'((i * 29 + run * 7) & 255);
    b   = 8'((i * 113 + 5) & 255);
    cin = i[2];
    sub = i[1];
    case (i)
      0: begin a = 8'h05; b = 8'h07; cin = 1'b0; sub = 1'b1; end
      1: begin a = 8'h80; b = 8'h01; cin = 1'b1; sub = 1'b1; end
      2: begin a = 8'h7F; b = 8'h01; cin = 1'b0; sub = 1'b0; end
      3: begin a = 8'hFF; b = 8'h01; cin = 1'b1; sub = 1'b0; end
      10: if (run == 3) begin a = 8'h7F; b = 8'h01; cin = 1'b0; sub = 1'b0; end
      default: ;
    endcase
  endtask

  // Driver: hold the vector until in_ready, then record the accept edge and expected outcome.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                      input logic [7:0] s, input logic cf, input logic of, input logic mis);
    int waitc;
    @(negedge CLK);
    A = a; B = b; Cin = cin; SUB = sub; S = s; CF = cf; OF = of;
    in_valid = 1'b1;
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(negedge CLK);
      waitc++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back({32'(cyc + 1), mis});
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      in_valid = 1'b0;
    end
  endtask

  task automatic run_vectors(input int run, input int count);
    logic [7:0] a, b, s;
    logic cin, sub, cf, of, mis;
    logic [9:0] r;
    first_fail_seen = 1'b0;
    for (int i = 0; i < count; i++) begin
      get_vec(i, run, a, b, cin, sub);
      r   = model(a, b, cin, sub);
      cf  = r[9];
      of  = r[8];
      s   = r[7:0];
      mis = 1'b0;
      if (run == 2 && (i == 5 || i == 200)) begin
        if (!first_fail_seen) begin
          first_fail_exp  = s;
          first_fail_obs  = s ^ 8'h5A;
          first_fail_seen = 1'b1;
        end
        s   = s ^ 8'h5A;
        mis = 1'b1;
      end
      if (run == 3 && i == 10) begin
        of  = 1'b0;
        mis = 1'b1;
      end
      if (run == 1 && i == 50) START = 1'b1;
      send(a, b, cin, sub, s, cf, of, mis);
      START = 1'b0;
      idle($urandom_range(0, 2));
    end
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic start_run(input logic with_valid, input int run);
    logic [7:0] a, b;
    logic cin, sub;
    logic [9:0] r;
    @(negedge CLK);
    START = 1'b1;
    if (with_valid) begin
      get_vec(0, run, a, b, cin, sub);
      r = model(a, b, cin, sub);
      A = a; B = b; Cin = cin; SUB = sub; S = r[7:0]; CF = r[9]; OF = r[8];
      in_valid = 1'b1;
    end
    @(posedge CLK);
    #1;
    START = 1'b0;
    exp_q.delete();
    exp_err = 0;
    check("start_busy", busy, 1);
    check("start_chk_cleared", chk_count, 0);
  endtask

  task automatic wait_done(input string name);
    int w;
    w = 0;
    while (!done && w < 20) begin
      @(negedge CLK);
      w++;
    end
    check(name, done, 1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_in_ready"}, in_ready, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_pass"}, pass, 0);
    check({name, "_mismatch"}, mismatch, 0);
    check({name, "_err"}, err_count, 0);
    check({name, "_chk"}, chk_count, 0);
    check({name, "_fidx"}, fail_index, 0);
    check({name, "_fexp"}, fail_s_exp, 0);
    check({name, "_fobs"}, fail_s_obs, 0);
    check({name, "_state"}, state_dbg, 0);
  endtask

  // Monitor: every increment of chk_count is one completed check; pop and compare it.
  initial begin
    logic [32:0] rec;
    forever begin
      @(negedge CLK);
      if (RST === 1'b1) begin
        if (chk_count == prev_chk + 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_check", 32'd1, 32'd0);
          end else begin
            rec = exp_q.pop_front();
            check("check_latency", 32'(cyc), rec[32:1] + 32'd1);
            check("mismatch", mismatch, rec[0]);
            if (rec[0]) exp_err++;
            check("err_count", err_count, 32'(exp_err));
          end
        end else begin
          check("idle_mismatch", mismatch, 0);
        end
      end
      prev_chk = chk_count;
    end
  end

  initial begin
    int w;
    RST = 1'b0; START = 1'b0; in_valid = 1'b0;
    A = '0; B = '0; Cin = 1'b0; SUB = 1'b0; S = '0; CF = 1'b0; OF = 1'b0;
    start2 = 1'b0; valid2 = 1'b0;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    @(negedge CLK);
    RST = 1'b1;

    // Run 1: all correct, directed add/sub/overflow vectors at the front, START mid-run ignored
    start_run(1'b0, 1);
    run_vectors(1, NV);
    wait_done("run1_done");
    check("run1_pass", pass, 1);
    check("run1_err", err_count, 0);
    check("run1_chk", chk_count, 256);
    check("run1_busy", busy, 0);
    check("run1_state", state_dbg, 2);

    // Saturation: six failing vectors into a 2-bit error counter
    @(negedge CLK);
    start2 = 1'b1;
    @(posedge CLK);
    #1;
    start2 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      A = 8'(k); B = 8'h03; Cin = 1'b0; SUB = 1'b0; S = 8'(k + 4); CF = 1'b0; OF = 1'b0;
      valid2 = 1'b1;
      w = 0;
      while (!ready2 && w < 20) begin
        @(negedge CLK);
        w++;
      end
      @(posedge CLK);
      #1;
    end
    @(negedge CLK);
    valid2 = 1'b0;
    w = 0;
    while (!done2 && w < 20) begin
      @(negedge CLK);
      w++;
    end
    check("sat_done", done2, 1);
    check("sat_err", err2, 3);
    check("sat_pass", pass2, 0);
    check("sat_chk", chk2, 6);
`ifdef CHECKER_FIRST_FAIL_CAPTURE_EN
    check("sat_fexp", fse2, 8'h03);
    check("sat_fobs", fso2, 8'h04);
`else
    check("sat_fexp", fse2, 0);
    check("sat_fobs", fso2, 0);
`endif

    // Run 2: START from DONE with in_valid already high, S corrupted at vectors 5 and 200
    start_run(1'b1, 2);
    run_vectors(2, NV);
    wait_done("run2_done");
    check("run2_err", err_count, 2);
    check("run2_pass", pass, 0);
    check("run2_chk", chk_count, 256);
`ifdef CHECKER_FIRST_FAIL_CAPTURE_EN
    check("run2_fidx", fail_index, 5);
    check("run2_fexp", fail_s_exp, 32'(first_fail_exp));
    check("run2_fobs", fail_s_obs, 32'(first_fail_obs));
`else
    check("run2_fidx", fail_index, 0);
    check("run2_fexp", fail_s_exp, 0);
    check("run2_fobs", fail_s_obs, 0);
`endif

    // Run 3: overflow mismatch at vector 10, then reset after 100 accepts
    start_run(1'b0, 3);
    run_vectors(3, 100);
    @(negedge CLK);
    #1;
    RST = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    exp_err = 0;
    #1;
    check_all_zero("midreset");
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check_all_zero("post_reset_idle");

    // Run 4: fresh run after reset completes normally
    start_run(1'b0, 4);
    run_vectors(4, NV);
    wait_done("run4_done");
    check("run4_pass", pass, 1);
    check("run4_err", err_count, 0);
    check("run4_chk", chk_count, 256);
    check("run4_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
